// File: rtl/rtype_control_sequencer.sv
// Control-step sequencer for fetch plus register-register execute (T0-T6).
// Strobes are a Moore decode of the registered step and the instruction word.
module rtype_control_sequencer #(
  parameter int unsigned         NUM_REGS    = 16,
  parameter int unsigned         OPCODE_W    = 5,
  parameter logic [OPCODE_W-1:0] MUL_OPCODE  = 5'b01111,
  parameter logic [OPCODE_W-1:0] DIV_OPCODE  = 5'b10000,
  parameter int unsigned         MEM_TIMEOUT = 8
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                start,
  input  logic                run,
  input  logic                mem_ready,
  input  logic [31:0]         ir,
  output logic                PCout,
  output logic                MARin,
  output logic                IncPC,
  output logic                Zin,
  output logic                Zlowout,
  output logic                Zhighout,
  output logic                PCin,
  output logic                Read,
  output logic                MDRin,
  output logic                MDRout,
  output logic                IRin,
  output logic                Yin,
  output logic                HIin,
  output logic                LOin,
  output logic [NUM_REGS-1:0] Rout,
  output logic [NUM_REGS-1:0] Rin,
  output logic [OPCODE_W-1:0] alu_op,
  output logic [2:0]          step,
  output logic                busy,
  output logic                done,
  output logic                fault,
  output logic                reg_fault
);

  localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_FAULT
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  wait_q, wait_d;

  logic [OPCODE_W-1:0] opcode;
  logic [3:0]          ra, rb, rc;
  logic                is_md;
  logic                unused_ir_bits;

  assign opcode         = ir[31 -: OPCODE_W];
  assign ra             = ir[26:23];
  assign rb             = ir[22:19];
  assign rc             = ir[18:15];
  assign is_md          = (opcode == MUL_OPCODE) || (opcode == DIV_OPCODE);
  assign unused_ir_bits = ^ir[14:0];

  // Indices at or above NUM_REGS select nothing rather than aliasing a register.
  function automatic logic [NUM_REGS-1:0] onehot(input logic [3:0] idx);
    onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx == 4'(i)) onehot[i] = 1'b1;
    end
  endfunction

  function automatic logic in_range(input logic [3:0] idx);
    return {1'b0, idx} < 5'(NUM_REGS);
  endfunction

  always_comb begin
    // NOTE: every variable gets a default before the case so no latch is inferred.
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_T0;
      S_T0:    state_d = S_T1;
      S_T1: begin
        // mem_ready is tested first so it wins on the timeout cycle.
        if (mem_ready)                state_d = S_T2;
        else if (wait_q == WAIT_LAST) state_d = S_FAULT;
        else                          wait_d  = wait_q + CNT_W'(1);
      end
      S_T2:    state_d = S_T3;
      S_T3:    state_d = S_T4;
      S_T4:    state_d = S_T5;
      S_T5:    state_d = is_md ? S_T6 : (run ? S_T0 : S_IDLE);
      S_T6:    state_d = run ? S_T0 : S_IDLE;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_T0) wait_d = '0;
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    {PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin,
     Read, MDRin, MDRout, IRin, Yin, HIin, LOin} = 14'b0;
    Rout      = '0;
    Rin       = '0;
    alu_op    = '0;
    step      = 3'd0;
    busy      = 1'b0;
    done      = 1'b0;
    fault     = 1'b0;
    reg_fault = 1'b0;
    unique case (state_q)
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
        step  = 3'd0; busy  = 1'b1;
      end
      S_T1: begin
        Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
        step    = 3'd1; busy = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        step   = 3'd2; busy = 1'b1;
      end
      S_T3: begin
        Rout      = onehot(rb);
        Yin       = 1'b1;
        reg_fault = !in_range(rb);
        step      = 3'd3; busy = 1'b1;
      end
      S_T4: begin
        Rout      = onehot(rc);
        Zin       = 1'b1;
        alu_op    = opcode;
        reg_fault = !in_range(rc);
        step      = 3'd4; busy = 1'b1;
      end
      S_T5: begin
        Zlowout = 1'b1;
        step    = 3'd5; busy = 1'b1;
        if (is_md) begin
          LOin = 1'b1;
        end else begin
          Rin       = onehot(ra);
          done      = 1'b1;
          reg_fault = !in_range(ra);
        end
      end
      S_T6: begin
        Zhighout = 1'b1; HIin = 1'b1; done = 1'b1;
        step     = 3'd6; busy = 1'b1;
      end
      S_FAULT: fault = 1'b1;
      default: ;
    endcase
  end

endmodule
